// File: rtl/task_dispatcher_pkg.sv
// Shared definitions for the task dispatcher: FSM encoding and core indexing.
package task_dispatcher_pkg;

  localparam int NUM_CORES  = 3;
  localparam int CORE_IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SELECT   = 2'd1,
    ST_DISPATCH = 2'd2
  } disp_state_t;

  typedef logic [CORE_IDX_W-1:0] core_idx_t;

endpackage

// File: rtl/task_fifo.sv
// Task FIFO with one extra pointer bit so full and empty are distinguishable
// without a separate occupancy counter.
module task_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head      = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; wrap of the extra bit keeps full/empty lossless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/task_dispatcher.sv
// Queues tasks and hands each one to the coolest idle core, retrying on
// another core when the chosen one fails to acknowledge in time.
module task_dispatcher #(
  parameter int         DEPTH      = 4,
  parameter logic [7:0] TEMP_LIMIT = 8'd80,
  parameter int         TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        task_valid,
  input  logic [15:0] task_data,
  output logic        task_ready,
  input  logic [7:0]  temp_core0,
  input  logic [7:0]  temp_core1,
  input  logic [7:0]  temp_core2,
  input  logic [2:0]  core_busy,
  output logic        dispatch_valid,
  output logic [15:0] dispatch_data,
  output logic [1:0]  core_select,
  input  logic        dispatch_ack,
  output logic        throttle,
  output logic        err_timeout,
  output logic [7:0]  dispatch_count
);

  import task_dispatcher_pkg::*;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  disp_state_t state_r;
  disp_state_t next_state_s;

  logic        fifo_push_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [15:0] fifo_head_s;

  logic [7:0]           temp_s [NUM_CORES];
  logic [NUM_CORES-1:0] elig_s;
  logic                 any_elig_s;
  core_idx_t            best_idx_s;
  logic [7:0]           best_temp_s;
  logic                 hot_all_s;

  logic        load_sel_s;
  logic        pop_s;
  logic        timeout_s;
  logic [15:0] timeout_cnt_r;
  logic        mask_valid_r;
  core_idx_t   mask_idx_r;

  logic        dispatch_valid_r;
  logic [15:0] dispatch_data_r;
  core_idx_t   core_select_r;
  logic        throttle_r;
  logic        err_timeout_r;
  logic [7:0]  dispatch_count_r;

  assign fifo_push_s = task_valid && !fifo_full_s;
  assign task_ready  = !fifo_full_s;

  task_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push_s),
    .wr_data (task_data),
    .pop     (pop_s),
    .head    (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  assign temp_s[0] = temp_core0;
  assign temp_s[1] = temp_core1;
  assign temp_s[2] = temp_core2;
  assign hot_all_s = (temp_core0 >= TEMP_LIMIT) && (temp_core1 >= TEMP_LIMIT)
                  && (temp_core2 >= TEMP_LIMIT);

  // Coolest eligible core; strict less-than keeps ties on the lowest index.
  always_comb begin
    elig_s      = '0;
    any_elig_s  = 1'b0;
    best_idx_s  = '0;
    best_temp_s = 8'hFF;
    for (int i = 0; i < NUM_CORES; i++) begin
      elig_s[i] = !core_busy[i] && (temp_s[i] < TEMP_LIMIT)
               && !(mask_valid_r && (mask_idx_r == CORE_IDX_W'(i)));
      if (elig_s[i] && (!any_elig_s || (temp_s[i] < best_temp_s))) begin
        any_elig_s  = 1'b1;
        best_idx_s  = CORE_IDX_W'(i);
        best_temp_s = temp_s[i];
      end else begin
        any_elig_s  = any_elig_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and control decode; ack wins over a coincident timeout.
  always_comb begin
    next_state_s = state_r;
    load_sel_s   = 1'b0;
    pop_s        = 1'b0;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          next_state_s = ST_SELECT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SELECT: begin
        if (any_elig_s) begin
          next_state_s = ST_DISPATCH;
          load_sel_s   = 1'b1;
        end else begin
          next_state_s = ST_SELECT;
        end
      end
      ST_DISPATCH: begin
        if (dispatch_ack) begin
          next_state_s = ST_IDLE;
          pop_s        = 1'b1;
        end else if (timeout_cnt_r == TO_LAST) begin
          next_state_s = ST_SELECT;
          timeout_s    = 1'b1;
        end else begin
          next_state_s = ST_DISPATCH;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Unacknowledged-cycle counter and the one-shot mask of a timed-out core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_cnt_r <= 16'd0;
      mask_valid_r  <= 1'b0;
      mask_idx_r    <= '0;
    end else begin
      if ((state_r == ST_DISPATCH) && !dispatch_ack && !timeout_s) begin
        timeout_cnt_r <= timeout_cnt_r + 16'd1;
      end else begin
        timeout_cnt_r <= 16'd0;
      end
      if (timeout_s) begin
        mask_valid_r <= 1'b1;
        mask_idx_r   <= core_select_r;
      end else if (state_r == ST_SELECT) begin
        mask_valid_r <= 1'b0;
      end
    end
  end

  // Dispatch-side output registers; selection is frozen while dispatching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dispatch_valid_r <= 1'b0;
      dispatch_data_r  <= 16'd0;
      core_select_r    <= '0;
      err_timeout_r    <= 1'b0;
      dispatch_count_r <= 8'd0;
    end else begin
      if (load_sel_s) begin
        dispatch_valid_r <= 1'b1;
        core_select_r    <= best_idx_s;
        dispatch_data_r  <= fifo_head_s;
      end else if (pop_s || timeout_s) begin
        dispatch_valid_r <= 1'b0;
      end
      if (pop_s) begin
        dispatch_count_r <= dispatch_count_r + 8'd1;
      end
      if (timeout_s) begin
        err_timeout_r <= 1'b1;
      end
    end
  end

  // Thermal throttle flag, sampled every cycle regardless of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      throttle_r <= 1'b0;
    end else begin
      throttle_r <= hot_all_s;
    end
  end

  assign dispatch_valid = dispatch_valid_r;
  assign dispatch_data  = dispatch_data_r;
  assign core_select    = core_select_r;
  assign throttle       = throttle_r;
  assign err_timeout    = err_timeout_r;
  assign dispatch_count = dispatch_count_r;

endmodule

// File: tb/tb_task_dispatcher.sv
// Self-checking bench for task_dispatcher: directed scenarios plus randomized
// dispatches compared against a queue-based reference model.
module tb_task_dispatcher;

  localparam int         DEPTH      = 4;
  localparam int         TIMEOUT    = 16;
  localparam logic [7:0] TEMP_LIMIT = 8'd80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        task_valid = 1'b0;
  logic [15:0] task_data = 16'd0;
  logic        task_ready;
  logic [7:0]  temp_core0 = 8'd40;
  logic [7:0]  temp_core1 = 8'd50;
  logic [7:0]  temp_core2 = 8'd60;
  logic [2:0]  core_busy = 3'b000;
  logic        dispatch_valid;
  logic [15:0] dispatch_data;
  logic [1:0]  core_select;
  logic        dispatch_ack = 1'b0;
  logic        throttle;
  logic        err_timeout;
  logic [7:0]  dispatch_count;

  int          n_checks = 0;
  int          n_fail = 0;
  int          model_count = 0;
  bit          model_err = 1'b0;
  logic [15:0] model_q[$];

  always #5 clk = ~clk;

  task_dispatcher #(
    .DEPTH      (DEPTH),
    .TEMP_LIMIT (TEMP_LIMIT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .task_valid     (task_valid),
    .task_data      (task_data),
    .task_ready     (task_ready),
    .temp_core0     (temp_core0),
    .temp_core1     (temp_core1),
    .temp_core2     (temp_core2),
    .core_busy      (core_busy),
    .dispatch_valid (dispatch_valid),
    .dispatch_data  (dispatch_data),
    .core_select    (core_select),
    .dispatch_ack   (dispatch_ack),
    .throttle       (throttle),
    .err_timeout    (err_timeout),
    .dispatch_count (dispatch_count)
  );

  // Reference selection: coolest idle core below the limit, ties to lowest index.
  function automatic int model_pick(input logic [7:0] t0, input logic [7:0] t1,
                                    input logic [7:0] t2, input logic [2:0] busy,
                                    input int masked);
    int t[3];
    int best;
    t[0] = int'(t0);
    t[1] = int'(t1);
    t[2] = int'(t2);
    best = -1;
    for (int i = 0; i < 3; i++) begin
      if (!busy[i] && t[i] < int'(TEMP_LIMIT) && i != masked && (best < 0 || t[i] < t[best]))
        best = i;
    end
    return best;
  endfunction

  task automatic set_env(input logic [7:0] t0, input logic [7:0] t1,
                         input logic [7:0] t2, input logic [2:0] busy);
    temp_core0 = t0;
    temp_core1 = t1;
    temp_core2 = t2;
    core_busy  = busy;
  endtask

  task automatic push(input logic [15:0] d);
    task_valid = 1'b1;
    task_data  = d;
    @(negedge clk);
    task_valid = 1'b0;
    model_q.push_back(d);
  endtask

  task automatic do_ack();
    dispatch_ack = 1'b1;
    @(negedge clk);
    dispatch_ack = 1'b0;
    void'(model_q.pop_front());
    model_count++;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dispatch_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (dispatch_valid === 1'b1) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dispatch_valid, dispatch_data, core_select, throttle, err_timeout, dispatch_count} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {dispatch_valid, dispatch_data, core_select, throttle, err_timeout, dispatch_count});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_q.delete();
    model_count = 0;
    model_err = 1'b0;
    @(negedge clk);
    n_checks++;
    if (task_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 1", task_ready);
    end
  endtask

  task automatic test_latency();
    int exp_core;
    set_env(8'd40, 8'd50, 8'd60, 3'b000);
    exp_core = model_pick(8'd40, 8'd50, 8'd60, 3'b000, -1);
    push(16'd1234);
    n_checks++;
    if (dispatch_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_n0: valid=%b expected 0", dispatch_valid);
    end
    @(negedge clk);
    n_checks++;
    if (dispatch_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_n1: valid=%b expected 0", dispatch_valid);
    end
    @(negedge clk);
    n_checks++;
    if ({dispatch_valid, core_select, dispatch_data} !== {1'b1, 2'(exp_core), model_q[0]}) begin
      n_fail++;
      $display("FAIL latency_n2: valid=%b core=%0d data=%0d expected 1/%0d/%0d",
               dispatch_valid, core_select, dispatch_data, exp_core, model_q[0]);
    end
    do_ack();
    n_checks++;
    if ({dispatch_valid, dispatch_count} !== {1'b0, 8'(model_count)}) begin
      n_fail++;
      $display("FAIL latency_ack: valid=%b count=%0d expected 0/%0d",
               dispatch_valid, dispatch_count, model_count);
    end
  endtask

  task automatic test_selection();
    bit ok;
    int exp_core;
    logic [7:0] tv [2][3];
    logic [2:0] bv [2];
    tv[0][0] = 8'd70; tv[0][1] = 8'd30; tv[0][2] = 8'd30; bv[0] = 3'b010;
    tv[1][0] = 8'd30; tv[1][1] = 8'd30; tv[1][2] = 8'd30; bv[1] = 3'b000;
    for (int k = 0; k < 2; k++) begin
      set_env(tv[k][0], tv[k][1], tv[k][2], bv[k]);
      exp_core = model_pick(tv[k][0], tv[k][1], tv[k][2], bv[k], -1);
      push(16'hA000 + 16'(k));
      wait_valid(10, ok);
      n_checks++;
      if (!ok || core_select !== 2'(exp_core)) begin
        n_fail++;
        $display("FAIL select_%0d: valid=%b core=%0d expected 1/%0d", k, ok, core_select, exp_core);
      end
      do_ack();
    end
  endtask

  task automatic test_throttle();
    bit ok;
    set_env(8'd85, 8'd85, 8'd85, 3'b000);
    @(negedge clk);
    n_checks++;
    if (throttle !== 1'b1) begin
      n_fail++;
      $display("FAIL throttle_on: got %b expected 1", throttle);
    end
    push(16'h0BAD);
    repeat (8) @(negedge clk);
    n_checks++;
    if (dispatch_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL throttle_hold: valid=%b expected 0", dispatch_valid);
    end
    temp_core1 = 8'd60;
    wait_valid(10, ok);
    n_checks++;
    if (!ok || core_select !== 2'(model_pick(8'd85, 8'd60, 8'd85, 3'b000, -1))
        || dispatch_data !== 16'h0BAD) begin
      n_fail++;
      $display("FAIL throttle_release: valid=%b core=%0d data=%h expected 1/1/0bad",
               ok, core_select, dispatch_data);
    end
    n_checks++;
    if (throttle !== 1'b0) begin
      n_fail++;
      $display("FAIL throttle_off: got %b expected 0", throttle);
    end
    do_ack();
  endtask

  task automatic test_timeout();
    bit ok;
    bit stable;
    int n_high;
    int first_core;
    set_env(8'd40, 8'd50, 8'd60, 3'b000);
    first_core = model_pick(8'd40, 8'd50, 8'd60, 3'b000, -1);
    push(16'hBEEF);
    wait_valid(10, ok);
    n_high = 0;
    stable = 1'b1;
    while (dispatch_valid === 1'b1 && n_high < 100) begin
      if (core_select !== 2'(first_core)) stable = 1'b0;
      n_high++;
      @(negedge clk);
    end
    model_err = 1'b1;
    n_checks++;
    if (!ok || n_high != TIMEOUT || !stable) begin
      n_fail++;
      $display("FAIL timeout_len: high_cycles=%0d stable=%b expected %0d/1", n_high, stable, TIMEOUT);
    end
    n_checks++;
    if ({dispatch_valid, err_timeout} !== {1'b0, model_err}) begin
      n_fail++;
      $display("FAIL timeout_flag: valid=%b err=%b expected 0/1", dispatch_valid, err_timeout);
    end
    @(negedge clk);
    n_checks++;
    if ({dispatch_valid, core_select, dispatch_data}
        !== {1'b1, 2'(model_pick(8'd40, 8'd50, 8'd60, 3'b000, first_core)), model_q[0]}) begin
      n_fail++;
      $display("FAIL timeout_retry: valid=%b core=%0d data=%h expected 1/1/beef",
               dispatch_valid, core_select, dispatch_data);
    end
    do_ack();
    n_checks++;
    if (dispatch_count !== 8'(model_count)) begin
      n_fail++;
      $display("FAIL timeout_count: got %0d expected %0d", dispatch_count, model_count);
    end
  endtask

  task automatic test_full();
    bit ok;
    bit none;
    set_env(8'd40, 8'd50, 8'd60, 3'b000);
    for (int k = 0; k < DEPTH; k++) push(16'h1100 + 16'(k));
    n_checks++;
    if (task_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: got %b expected 0", task_ready);
    end
    task_valid = 1'b1;
    task_data  = 16'h5555;
    @(negedge clk);
    task_valid = 1'b0;
    n_checks++;
    if (task_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_hold: got %b expected 0", task_ready);
    end
    for (int k = 0; k < DEPTH; k++) begin
      wait_valid(20, ok);
      n_checks++;
      if (!ok || dispatch_data !== model_q[0]) begin
        n_fail++;
        $display("FAIL full_order_%0d: valid=%b data=%h expected 1/%h", k, ok, dispatch_data, model_q[0]);
      end
      do_ack();
    end
    n_checks++;
    if ({dispatch_count, err_timeout, task_ready} !== {8'(model_count), model_err, 1'b1}) begin
      n_fail++;
      $display("FAIL full_count: count=%0d err=%b ready=%b expected %0d/%b/1",
               dispatch_count, err_timeout, task_ready, model_count, model_err);
    end
    none = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (dispatch_valid !== 1'b0) none = 1'b0;
    end
    n_checks++;
    if (!none) begin
      n_fail++;
      $display("FAIL full_no_fifth: extra dispatch seen, expected none");
    end
  endtask

  task automatic test_random();
    bit ok;
    int exp_core;
    int dly;
    logic [7:0] t[3];
    logic [2:0] busy;
    logic [15:0] d;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 3; i++) t[i] = 8'($urandom_range(20, 100));
      busy = 3'($urandom_range(0, 7));
      if (model_pick(t[0], t[1], t[2], busy, -1) < 0) begin
        int c;
        c = $urandom_range(0, 2);
        busy[c] = 1'b0;
        t[c] = 8'($urandom_range(0, 79));
      end
      set_env(t[0], t[1], t[2], busy);
      exp_core = model_pick(t[0], t[1], t[2], busy, -1);
      d = 16'($urandom);
      push(d);
      wait_valid(10, ok);
      n_checks++;
      if (!ok || core_select !== 2'(exp_core) || dispatch_data !== model_q[0]) begin
        n_fail++;
        $display("FAIL rand_%0d: valid=%b core=%0d data=%h expected 1/%0d/%h",
                 it, ok, core_select, dispatch_data, exp_core, model_q[0]);
      end
      n_checks++;
      if (throttle !== ((t[0] >= TEMP_LIMIT) && (t[1] >= TEMP_LIMIT) && (t[2] >= TEMP_LIMIT))) begin
        n_fail++;
        $display("FAIL rand_throttle_%0d: got %b for temps %0d/%0d/%0d", it, throttle, t[0], t[1], t[2]);
      end
      set_env(8'($urandom_range(0, 100)), 8'($urandom_range(0, 100)),
              8'($urandom_range(0, 100)), 3'($urandom_range(0, 7)));
      dly = $urandom_range(0, 5);
      repeat (dly) @(negedge clk);
      n_checks++;
      if (dispatch_valid !== 1'b1 || core_select !== 2'(exp_core)) begin
        n_fail++;
        $display("FAIL rand_hold_%0d: valid=%b core=%0d expected 1/%0d", it, dispatch_valid, core_select, exp_core);
      end
      do_ack();
      n_checks++;
      if (dispatch_count !== 8'(model_count)) begin
        n_fail++;
        $display("FAIL rand_count_%0d: got %0d expected %0d", it, dispatch_count, model_count);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit none;
    set_env(8'd40, 8'd50, 8'd60, 3'b000);
    push(16'h0001);
    push(16'h0002);
    push(16'h0003);
    wait_valid(10, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL midrst_pre: valid=%b expected 1", dispatch_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    model_count = 0;
    model_err = 1'b0;
    n_checks++;
    if ({dispatch_valid, dispatch_data, core_select, throttle, err_timeout, dispatch_count, task_ready}
        !== {29'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL midrst_outputs: valid=%b data=%h core=%0d thr=%b err=%b count=%0d ready=%b expected all 0, ready 1",
               dispatch_valid, dispatch_data, core_select, throttle, err_timeout, dispatch_count, task_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    none = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (dispatch_valid !== 1'b0) none = 1'b0;
    end
    n_checks++;
    if (!none || dispatch_count !== 8'(model_count)) begin
      n_fail++;
      $display("FAIL midrst_after: stale dispatch=%b count=%0d expected none/0", !none, dispatch_count);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_selection();
    test_throttle();
    test_timeout();
    test_full();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/task_dispatcher.md
TASK_DISPATCHER -- requirements
Module: task_dispatcher

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning task FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TEMP_LIMIT, default 8'd80, meaning the core temperature at or above which a core is ineligible.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning the clk cycles to wait for dispatch_ack before abandoning a dispatch attempt.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 task_valid  input  1  requester offers task_data.
REQ-007 task_data  input  16  task payload.
REQ-008 task_ready  output  1  FIFO can accept a task; equals !full.
REQ-009 temp_core0, temp_core1, temp_core2  input  8 each  decoded core temperatures from the UART receiver.
REQ-010 core_busy  input  3  bit i high means core i is occupied.
REQ-011 dispatch_valid  output  1  task presented to the selected core.
REQ-012 dispatch_data  output  16  task payload at FIFO head.
REQ-013 core_select  output  2  target core index 0..2; 2'd3 never driven while dispatch_valid is high.
REQ-014 dispatch_ack  input  1  selected core accepts the task.
REQ-015 throttle  output  1  all three cores are at or above TEMP_LIMIT.
REQ-016 err_timeout  output  1  sticky flag: at least one dispatch attempt timed out.
REQ-017 dispatch_count  output  8  count of completed dispatches, wraps 255->0.

Function
REQ-018 Push shall occur on an edge where task_valid && task_ready; there is no push while full and task_valid is ignored.
REQ-019 Pop shall occur only on the edge where dispatch_valid && dispatch_ack; push and pop on the same edge shall leave occupancy unchanged.
REQ-020 A core shall be eligible when core_busy[i]==0, temp_core_i < TEMP_LIMIT and it is not masked (REQ-026).
REQ-021 The selection rule shall pick the eligible core with the lowest temperature, with ties going to the lowest index.
REQ-022 The FSM shall have states IDLE, SELECT and DISPATCH.
REQ-023 IDLE->SELECT shall occur when the FIFO is non-empty.
REQ-024 In SELECT, the FSM shall register core_select and go to DISPATCH if any core is eligible, else stay in SELECT.
REQ-025 In DISPATCH, dispatch_valid shall be high and core_select and dispatch_data held stable; on ack it shall pop, increment dispatch_count, deassert dispatch_valid, and go to IDLE.
REQ-026 The timeout counter shall count DISPATCH cycles without ack; at TIMEOUT it shall deassert dispatch_valid, set err_timeout, mask that core for the next SELECT evaluation only, go to SELECT, and keep the task at the FIFO head.
REQ-027 Latency: a task pushed into an empty FIFO on edge N shall have dispatch_valid high from edge N+2, provided a core is eligible.
REQ-028 Temperatures shall be compared only in SELECT; changes during DISPATCH shall not alter core_select.
REQ-029 throttle shall be registered and updated every cycle independent of FSM state.
REQ-030 FIFO pointers shall be log2(DEPTH)+1 bits, with full/empty derived from the MSB difference; pointer wrap shall be lossless.

Reset
REQ-031 On rst_n low, the block shall go to IDLE, empty the FIFO, and set task_ready=1 after release.
REQ-032 On rst_n low, the following outputs shall be 0: dispatch_valid, dispatch_data, core_select, throttle, err_timeout and dispatch_count.
REQ-033 Reset asserted mid-DISPATCH shall drop dispatch_valid immediately (asynchronously) and discard all queued tasks.

Structure
REQ-034 A shared package shall hold the FSM state encoding, NUM_CORES=3, and the core-index width.
REQ-035 The FIFO shall be one sub-module, task_fifo, with push/pop/full/empty/head ports; selection and the FSM stay in task_dispatcher.

Verification
REQ-036 Reset release, temps 40/50/60, no busy, push 16'd1234 -> dispatch_valid at N+2, core_select=0, ack -> dispatch_count=1.
REQ-037 Temps 70/30/30, core_busy=3'b010 -> core_select=2; with temps 30/30/30 and no busy -> core_select=0.
REQ-038 All temps 8'd85 -> throttle=1, FSM holds in SELECT; temp_core1 drops to 60 -> dispatch to core 1.
REQ-039 No ack for 16 cycles -> dispatch_valid low, err_timeout=1, re-dispatch to next-best core with the same task_data.
REQ-040 Push 4 tasks with ack held low -> task_ready=0 while full; a 5th task_valid is not accepted; ack all -> tasks exit in FIFO order, count=4.
REQ-041 Assert rst_n low during DISPATCH with 3 tasks queued -> all outputs 0, FIFO empty, no dispatch after release.
